instr_mem_loader: RTL and testbench

Write-side companion to the instruction memory: fills the 24-bit x 1024 instruction store from a byte stream (host link or UART RX) before the core starts fetching.

---
 rtl/instr_load_pkg.sv | 20 ++
 rtl/byte_word_packer.sv | 53 +++++
 rtl/instr_mem_loader.sv | 151 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_load_pkg.sv
// Shared types and sizing constants for the instruction-memory loader.
// Default instruction store: 24-bit words, 1024 deep.
package instr_load_pkg;

  localparam int INSTR_W        = 24;
  localparam int MEM_DEPTH      = 1024;
  localparam int BYTES_PER_WORD = INSTR_W / 8;
  localparam int LEN_BYTES      = 2;
  localparam int MAX_WORDS      = MEM_DEPTH;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    FIN
  } loader_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs an MSB-first byte stream into N-bit words.
// word_valid marks the handshake that completes a word; word is the assembled value on that cycle.
module byte_word_packer
  import instr_load_pkg::*;
#(
  parameter int N = INSTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   byte_data,
  output logic         word_valid,
  output logic [N-1:0] word
);

  localparam int BPW   = N / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0] byte_idx;

  assign word_valid = en && (byte_idx == IDX_W'(BPW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
    end else if (clr) begin
      byte_idx <= '0;
    end else if (en) begin
      byte_idx <= word_valid ? '0 : byte_idx + IDX_W'(1);
    end
  end

  // Only the older N-8 bits need storing; the newest byte comes straight from the input.
  if (BPW > 1) begin : g_shift
    logic [N-9:0] shift;

    assign word = {shift, byte_data};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shift <= '0;
      end else if (clr) begin
        shift <= '0;
      end else if (en) begin
        shift <= word[N-9:0];
      end
    end
  end else begin : g_single
    assign word = byte_data;
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Fills the instruction store from a byte stream: 16-bit big-endian word count, then
// N/8 bytes per word MSB first, written to consecutive addresses from 0.
//
// state  | meaning
// IDLE   | waiting for start; core free to fetch
// LEN_HI | accepting word-count high byte
// LEN_LO | accepting word-count low byte; length checked here
// DATA   | accepting instruction bytes
// WRITE  | one-cycle write strobe of the assembled word
// FIN    | done pulse, back to IDLE
module instr_mem_loader
  import instr_load_pkg::*;
#(
  parameter int N      = INSTR_W,
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [N-1:0]      mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  loader_state_t     state, state_nxt;
  logic              hs;
  logic              len_bad;
  logic              last_word;
  logic              word_valid;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       len_full;
  logic [ADDR_W-1:0] word_idx;
  logic [N-1:0]      packed_word;

  assign hs        = byte_valid & byte_ready;
  assign len_full  = {len_hi, byte_data};
  assign len_bad   = (len_full == 16'd0) || ({16'd0, len_full} > 32'(DEPTH));
  assign last_word = (32'(word_idx) + 32'd1) == {16'd0, len};

  byte_word_packer #(.N(N)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (state != DATA),
    .en         (hs && (state == DATA)),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (packed_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LEN_HI;
      LEN_HI: begin
        if (abort)   state_nxt = IDLE;
        else if (hs) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (abort)   state_nxt = IDLE;
        else if (hs) state_nxt = len_bad ? IDLE : DATA;
      end
      DATA: begin
        if (abort)           state_nxt = IDLE;
        else if (word_valid) state_nxt = WRITE;
      end
      WRITE: begin
        if (abort)          state_nxt = IDLE;
        else if (last_word) state_nxt = FIN;
        else                state_nxt = DATA;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // The write in WRITE always lands, even with abort, so the counters advance regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_hi     <= '0;
      len        <= '0;
      word_idx   <= '0;
      word_count <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            word_idx   <= '0;
            word_count <= '0;
          end
        end
        LEN_HI: if (hs && !abort) len_hi <= byte_data;
        LEN_LO: begin
          if (hs && !abort) begin
            len <= len_full;
            err <= len_bad;
          end
        end
        DATA: begin
          if (word_valid && !abort) begin
            mem_addr  <= word_idx;
            mem_wdata <= packed_word;
          end
        end
        WRITE: begin
          word_count <= word_count + (ADDR_W+1)'(1);
          if (!last_word) word_idx <= word_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus queues expected writes/done/err events,
// a monitor pops and compares them whenever the DUT strobes mem_we, done or err.
module tb_instr_mem_loader;

  localparam int K_WR   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] word_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;

  typedef struct {
    int          kind;
    logic [9:0]  addr;
    logic [23:0] data;
    logic [10:0] cnt;
  } exp_t;

  exp_t q[$];

  instr_mem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_wr(input int a, input int d);
    exp_t e;
    e.kind = K_WR; e.addr = 10'(a); e.data = 24'(d); e.cnt = '0;
    q.push_back(e);
  endtask

  task automatic exp_ev(input int kind, input int cnt);
    exp_t e;
    e.kind = kind; e.addr = '0; e.data = '0; e.cnt = 11'(cnt);
    q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (mem_we) begin
          n_wr++;
          check("wr_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("wr_kind", 32'(e.kind), 32'(K_WR));
            check("wr_addr", 32'(mem_addr), 32'(e.addr));
            check("wr_data", 32'(mem_wdata), 32'(e.data));
          end
        end
        if (done) begin
          check("done_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("done_kind", 32'(e.kind), 32'(K_DONE));
            check("done_word_count", 32'(word_count), 32'(e.cnt));
            check("done_busy", 32'(busy), 32'd0);
          end
        end
        if (err) begin
          check("err_expected", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("err_kind", 32'(e.kind), 32'(K_ERR));
            check("err_word_count", 32'(word_count), 32'(e.cnt));
            check("err_busy", 32'(busy), 32'd0);
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n == 64) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$], input bit rand_gap);
    foreach (bytes[i]) send_byte(bytes[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start(input logic with_abort);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] f[$];
    int wr_base;

    repeat (2) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_mem_we",     32'(mem_we),     32'd0);
    check("rst_done_err",   32'({done, err}), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_mem_addr",   32'(mem_addr),   32'd0);
    check("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // bytes offered in IDLE are refused
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      check("idle_byte_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;

    // normal two-word load
    exp_wr(0, 24'h123456);
    exp_wr(1, 24'hABCDEF);
    exp_ev(K_DONE, 2);
    pulse_start(1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    send_frame(f, 1'b0);
    wait_idle("normal_idle");
    check("normal_word_count", 32'(word_count), 32'd2);
    check("normal_drain", 32'(q.size()), 32'd0);

    // zero length
    exp_ev(K_ERR, 0);
    pulse_start(1'b0);
    f = '{8'h00, 8'h00};
    send_frame(f, 1'b0);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // 1025 words: one too many
    exp_ev(K_ERR, 0);
    pulse_start(1'b0);
    f = '{8'h04, 8'h01};
    send_frame(f, 1'b0);
    check("len1025_busy", 32'(busy), 32'd0);
    check("len1025_word_count", 32'(word_count), 32'd0);
    repeat (2) @(negedge clk);
    check("illegal_drain", 32'(q.size()), 32'd0);

    // three words with random valid gaps
    wr_base = n_wr;
    exp_wr(0, 24'h112233);
    exp_wr(1, 24'h445566);
    exp_wr(2, 24'h778899);
    exp_ev(K_DONE, 3);
    pulse_start(1'b0);
    f = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    send_frame(f, 1'b1);
    wait_idle("gaps_idle");
    check("gaps_we_pulses", 32'(n_wr - wr_base), 32'd3);
    check("gaps_drain", 32'(q.size()), 32'd0);

    // full depth: word i = i
    for (int i = 0; i < 1024; i++) exp_wr(i, i);
    exp_ev(K_DONE, 1024);
    pulse_start(1'b0);
    f = '{8'h04, 8'h00};
    send_frame(f, 1'b0);
    for (int i = 0; i < 1024; i++) begin
      send_byte(8'h00, 0);
      send_byte(8'(i >> 8), 0);
      send_byte(8'(i), 0);
    end
    wait_idle("full_idle");
    check("full_word_count", 32'(word_count), 32'd1024);
    check("full_last_addr", 32'(mem_addr), 32'd1023);
    check("full_last_data", 32'(mem_wdata), 32'h0003FF);
    check("full_drain", 32'(q.size()), 32'd0);

    // start while busy ignored; abort landing on the second WRITE
    exp_wr(0, 24'h010203);
    exp_wr(1, 24'h040506);
    pulse_start(1'b0);
    f = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(f, 1'b0);
    pulse_start(1'b0);
    check("start_busy_ignored", 32'(busy), 32'd1);
    check("start_busy_count", 32'(word_count), 32'd1);
    f = '{8'h05, 8'h06};
    send_frame(f, 1'b0);
    check("abort_in_write_we", 32'(mem_we), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_word_count", 32'(word_count), 32'd2);
    check("abort_drain", 32'(q.size()), 32'd0);

    exp_wr(0, 24'h0A0B0C);
    exp_ev(K_DONE, 1);
    pulse_start(1'b0);
    f = '{8'h00, 8'h01, 8'h0A, 8'h0B, 8'h0C};
    send_frame(f, 1'b0);
    wait_idle("restart_idle");
    check("restart_drain", 32'(q.size()), 32'd0);

    // reset between bytes of word 1
    exp_wr(0, 24'h212223);
    pulse_start(1'b0);
    f = '{8'h00, 8'h02, 8'h21, 8'h22, 8'h23, 8'h31, 8'h32};
    send_frame(f, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_busy",       32'(busy),       32'd0);
    check("arst_byte_ready", 32'(byte_ready), 32'd0);
    check("arst_mem_we",     32'(mem_we),     32'd0);
    check("arst_word_count", 32'(word_count), 32'd0);
    check("arst_mem_wdata",  32'(mem_wdata),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_drain", 32'(q.size()), 32'd0);

    // start and abort together in IDLE: start wins
    exp_wr(0, 24'h414243);
    exp_ev(K_DONE, 1);
    pulse_start(1'b1);
    check("start_abort_busy", 32'(busy), 32'd1);
    f = '{8'h00, 8'h01, 8'h41, 8'h42, 8'h43};
    send_frame(f, 1'b0);
    wait_idle("post_rst_idle");
    check("post_rst_word_count", 32'(word_count), 32'd1);
    check("final_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
